// File: rtl/bit_packer.sv
// Serial-to-parallel bit packer: LSB-first packing into WORD_W-bit words,
// queued in a DEPTH-entry FIFO with valid/ready drain, flush and overflow flag.
module bit_packer #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(WORD_W+1)
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       bit_in,
  input  logic                       bit_in_valid,
  input  logic                       flush,
  output logic [WORD_W-1:0]          word_out,
  output logic [CNT_W-1:0]           word_out_nbits,
  output logic                       word_out_last,
  output logic                       word_out_valid,
  input  logic                       word_out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic                       drained
);

  localparam int PW  = $clog2(DEPTH);
  localparam int FCW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  nbits;
    logic              last;
  } entry_t;

  typedef enum logic {FILL, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0]    count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              drained_q, drained_d;

  logic   push_req, bit_drop;
  entry_t push_e;
  logic   full, empty, pop, do_push;
  entry_t head;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (flush) state_d = DRAIN;
      DRAIN:   if (count_d == '0) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // ---------------- FSM: outputs / packing datapath ----------------
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
    push_e   = '0;
    bit_drop = 1'b0;
    case (state_q)
      FILL: begin
        if (bit_in_valid) begin
          for (int i = 0; i < WORD_W; i++)
            if (cnt_q == CNT_W'(i)) sr_d[i] = bit_in;
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Same-edge bit is already folded in, so a flush on the last bit yields a full word.
        if (cnt_d == CNT_W'(WORD_W) || (flush && cnt_d != '0)) begin
          push_req     = 1'b1;
          push_e.data  = sr_d;
          push_e.nbits = cnt_d;
          push_e.last  = flush;
          sr_d         = '0;
          cnt_d        = '0;
        end
      end
      DRAIN:   bit_drop = bit_in_valid;
      default: ;
    endcase
  end

  assign drained_d = (state_q == DRAIN) && (state_d == FILL);

  // ---------------- FIFO ----------------
  assign full    = (count_q == FCW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty && word_out_ready;
  assign do_push = push_req && (!full || pop);
  assign count_d = count_q + FCW'(do_push) - FCW'(pop);
  assign ovf_d   = ovf_q || (push_req && full && !pop) || bit_drop;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      drained_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      drained_q <= drained_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_e;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Head fields are zeroed whenever nothing is queued.
  assign head           = mem_q[rd_ptr_q];
  assign word_out_valid = !empty;
  assign word_out       = empty ? '0 : head.data;
  assign word_out_nbits = empty ? '0 : head.nbits;
  assign word_out_last  = empty ? 1'b0 : head.last;
  assign fifo_count     = count_q;
  assign overflow       = ovf_q;
  assign drained        = drained_q;

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer: packing, flush, FIFO full/overflow, drain and reset.
module tb_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in, bit_in_valid, flush, ready;
  logic [15:0] word_out;
  logic [4:0]  nbits;
  logic        last, valid;
  logic [2:0]  fcount;
  logic        ovf, drained;

  int passed = 0;
  int total  = 0;

  logic [15:0] wq [5];
  logic [15:0] w5;

  bit_packer dut (
    .CLK(clk), .Reset(rst_n), .bit_in(bit_in), .bit_in_valid(bit_in_valid),
    .flush(flush), .word_out(word_out), .word_out_nbits(nbits),
    .word_out_last(last), .word_out_valid(valid), .word_out_ready(ready),
    .fifo_count(fcount), .overflow(ovf), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic v, input logic b, input logic f, input logic r);
    bit_in_valid = v; bit_in = b; flush = f; ready = r;
    @(posedge clk); #1;
    bit_in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, w[i], 1'b0, r);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(valid), 0);
    check({tag, ".word"},  32'(word_out), 0);
    check({tag, ".nbits"}, 32'(nbits), 0);
    check({tag, ".last"},  32'(last), 0);
    check({tag, ".count"}, 32'(fcount), 0);
    check({tag, ".ovf"},   32'(ovf), 0);
    check({tag, ".drn"},   32'(drained), 0);
  endtask

  // Async reset pulse placed between clock edges; outputs are checked while held.
  task automatic do_reset(input string tag);
    rst_n = 1'b0; bit_in_valid = 1'b0; bit_in = 1'b0; flush = 1'b0; ready = 1'b0;
    #2;
    check_idle(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    wq[0] = 16'hA001; wq[1] = 16'hB002; wq[2] = 16'hC003; wq[3] = 16'hD004; wq[4] = 16'hE005;
    w5 = 16'hF00F;
    rst_n = 1'b0; bit_in = 1'b0; bit_in_valid = 1'b0; flush = 1'b0; ready = 1'b0;
    #2;
    check_idle("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: full word with ready=1, visible one cycle
    send_word(16'h1111, 16, 1'b1);
    check("t1.valid", 32'(valid), 1);
    check("t1.word",  32'(word_out), 32'h1111);
    check("t1.nbits", 32'(nbits), 16);
    check("t1.last",  32'(last), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1.popv", 32'(valid), 0);
    check("t1.popw", 32'(word_out), 0);

    // 2: partial word via flush, drained after pop
    send_word(16'h001B, 5, 1'b0);
    check("t2.pre", 32'(valid), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t2.word",  32'(word_out), 32'h001B);
    check("t2.nbits", 32'(nbits), 5);
    check("t2.last",  32'(last), 1);
    check("t2.drn0",  32'(drained), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t2.valid", 32'(valid), 0);
    check("t2.drn1",  32'(drained), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2.drn2",  32'(drained), 0);
    check("t2.ovf",   32'(ovf), 0);

    // 3: fill FIFO, fifth word dropped, sticky overflow
    for (int k = 0; k < 4; k++) send_word(wq[k], 16, 1'b0);
    check("t3.cnt4", 32'(fcount), 4);
    check("t3.ovf0", 32'(ovf), 0);
    send_word(wq[4], 16, 1'b0);
    check("t3.cnt5", 32'(fcount), 4);
    check("t3.ovf1", 32'(ovf), 1);
    for (int k = 0; k < 4; k++) begin
      check("t3.head", 32'(word_out), 32'(wq[k]));
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("t3.empty", 32'(fcount), 0);
    check("t3.sticky", 32'(ovf), 1);

    // 4: simultaneous push and pop while full
    do_reset("t4rst");
    for (int k = 0; k < 4; k++) send_word(wq[k], 16, 1'b0);
    send_word(w5, 15, 1'b0);
    check("t4.cnt15", 32'(fcount), 4);
    step(1'b1, w5[15], 1'b0, 1'b1);
    check("t4.cnt",  32'(fcount), 4);
    check("t4.ovf",  32'(ovf), 0);
    check("t4.head", 32'(word_out), 32'(wq[1]));
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t4.w5",   32'(word_out), 32'(w5));
    check("t4.c1",   32'(fcount), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t4.c0",   32'(fcount), 0);
    check("t4.ovf2", 32'(ovf), 0);

    // 5: flush on the 16th bit, then a bit during DRAIN
    send_word(16'h8421, 15, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t5.cnt",   32'(fcount), 1);
    check("t5.word",  32'(word_out), 32'h8421);
    check("t5.nbits", 32'(nbits), 16);
    check("t5.last",  32'(last), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t5.ovf",   32'(ovf), 1);
    check("t5.cnt2",  32'(fcount), 1);
    check("t5.drn0",  32'(drained), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t5.c0",    32'(fcount), 0);
    check("t5.drn1",  32'(drained), 1);

    // 6: reset mid-word with two words queued
    do_reset("t6rst0");
    send_word(wq[0], 16, 1'b0);
    send_word(wq[1], 16, 1'b0);
    send_word(16'h01FF, 9, 1'b0);
    check("t6.cnt2", 32'(fcount), 2);
    do_reset("t6rst");
    send_word(16'h5A5A, 16, 1'b0);
    check("t6.cnt",   32'(fcount), 1);
    check("t6.word",  32'(word_out), 32'h5A5A);
    check("t6.nbits", 32'(nbits), 16);
    check("t6.last",  32'(last), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6.c0",    32'(fcount), 0);

    // 7: flush with no pending bits and empty FIFO
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t7.cnt",  32'(fcount), 0);
    check("t7.drn0", 32'(drained), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t7.drn1", 32'(drained), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t7.drn2", 32'(drained), 0);
    check("t7.ovf",  32'(ovf), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
